// File: rtl/am_symbol_feeder.sv
// am_symbol_feeder: buffers audio samples and converts one per PWM symbol tick into a thermometer word
`ifndef AM_PWM_STEPS
`define AM_PWM_STEPS 64
`endif
module am_symbol_feeder #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int PWM_STEPS    = `AM_PWM_STEPS,
  parameter int FIFO_DEPTH   = 8,
  parameter int PRIME_LEVEL  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SAMPLE_WIDTH-1:0]         s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            symb_tick,
  output logic [PWM_STEPS-1:0]            symbol_word,
  output logic                            symbol_load,
  output logic                            running,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     underrun_count
);
  localparam int DW = $clog2(PWM_STEPS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [PWM_STEPS-1:0] IDLE_WORD = {{(PWM_STEPS/2){1'b1}}, {(PWM_STEPS/2){1'b0}}};
  typedef enum logic {PRIME, RUN} state_t;
  state_t state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [PWM_STEPS-1:0] word_q, word_d, conv;
  logic load_q, load_d;
  logic [15:0] urun_q, urun_d;
  logic [SAMPLE_WIDTH-1:0] head;
  logic [DW-1:0] duty;
  logic push, pop, underrun;
  always_comb begin
    s_ready  = ~rst & (level_q != LW'(FIFO_DEPTH));
    push     = s_valid & s_ready;
    pop      = symb_tick & (state_q == RUN) & (level_q != '0);
    underrun = symb_tick & (state_q == RUN) & (level_q == '0);
    head     = mem_q[rd_q];
    duty     = DW'(head >> (SAMPLE_WIDTH - DW));
    conv     = ~({PWM_STEPS{1'b1}} >> duty);
    mem_d    = mem_q;
    if (push) mem_d[wr_q] = s_data;
    wr_d     = wr_q + AW'(push);
    rd_d     = rd_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    word_d   = symb_tick ? (pop ? conv : IDLE_WORD) : word_q;
    load_d   = symb_tick;
    urun_d   = urun_q + 16'(underrun & (urun_q != 16'hFFFF));
    state_d  = (state_q == PRIME) ? ((level_d >= LW'(PRIME_LEVEL)) ? RUN : PRIME)
                                  : (underrun ? PRIME : RUN);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      word_q  <= IDLE_WORD;
      load_q  <= 1'b0;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      word_q  <= word_d;
      load_q  <= load_d;
      urun_q  <= urun_d;
    end
  end
  assign symbol_word    = word_q;
  assign symbol_load    = load_q;
  assign running        = (state_q == RUN);
  assign fifo_level     = level_q;
  assign underrun_count = urun_q;
endmodule

// File: tb/tb_am_symbol_feeder.sv
// tb_am_symbol_feeder: directed scoreboard bench for am_symbol_feeder
module tb_am_symbol_feeder;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, symb_tick = 1'b0;
  logic [7:0] s_data = '0;
  logic s_ready, symbol_load, running;
  logic [63:0] symbol_word;
  logic [3:0] fifo_level;
  logic [15:0] underrun_count;
  int total = 0, bad = 0;
  logic [63:0] exp_q [$];
  logic tick_seen = 1'b0;
  localparam logic [63:0] IDLE = 64'hFFFF_FFFF_0000_0000;
  am_symbol_feeder dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .symb_tick(symb_tick), .symbol_word(symbol_word), .symbol_load(symbol_load),
    .running(running), .fifo_level(fifo_level), .underrun_count(underrun_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] wd(input logic [7:0] s);
    logic [63:0] w = '0;
    for (int i = 0; i < int'(s >> 2); i++) w[63-i] = 1'b1;
    return w;
  endfunction
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick(input logic [63:0] e);
    exp_q.push_back(e);
    symb_tick = 1'b1;
    step();
    symb_tick = 1'b0;
  endtask
  task automatic push(input logic [7:0] d);
    s_data = d;
    s_valid = 1'b1;
    for (int n = 0; n < 20 && !s_ready; n++) step();
    chk("push_ready", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
  endtask
  always @(posedge clk) tick_seen <= symb_tick & ~rst;
  always @(negedge clk) if (!rst) begin
    chk("load_timing", 64'(symbol_load), 64'(tick_seen));
    if (symbol_load) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL load_unexpected observed=%0h expected=none", symbol_word);
      end else chk("symbol_word", symbol_word, exp_q.pop_front());
    end
  end
  initial begin
    int acc;
    step(2);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_word", symbol_word, IDLE);
    chk("rst_load", 64'(symbol_load), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_urun", 64'(underrun_count), 64'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(s_ready), 64'd1);
    repeat (3) begin tick(IDLE); step(3); end
    chk("prime_running", 64'(running), 64'd0);
    chk("prime_urun", 64'(underrun_count), 64'd0);
    push(8'h00); push(8'h40); push(8'h80);
    chk("run_before_4th", 64'(running), 64'd0);
    push(8'hFF);
    chk("run_after_4th", 64'(running), 64'd1);
    chk("level_4", 64'(fifo_level), 64'd4);
    tick(64'h0); step(63);
    tick(64'hFFFF_0000_0000_0000); step(63);
    tick(64'hFFFF_FFFF_0000_0000); step(63);
    tick(64'hFFFF_FFFF_FFFF_FFFE); step(2);
    chk("drained_level", 64'(fifo_level), 64'd0);
    chk("drained_running", 64'(running), 64'd1);
    push(8'h20); push(8'h60); push(8'hA0); push(8'hE0);
    tick(wd(8'h20)); step(3);
    tick(wd(8'h60)); step(3);
    tick(wd(8'hA0)); step(3);
    tick(wd(8'hE0)); step(3);
    tick(IDLE); step();
    chk("underrun_count_1", 64'(underrun_count), 64'd1);
    chk("underrun_running", 64'(running), 64'd0);
    push(8'h04); push(8'h08); push(8'hFC); push(8'h7F);
    chk("reprime_running", 64'(running), 64'd1);
    tick(64'h8000_0000_0000_0000); tick(64'hC000_0000_0000_0000);
    tick(64'hFFFF_FFFF_FFFF_FFFE); tick(wd(8'h7F));
    step();
    chk("b2b_level", 64'(fifo_level), 64'd0);
    acc = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_data = 8'(16 * (acc + 1));
      if (s_ready) acc++;
      step();
    end
    chk("fill_count", 64'(acc), 64'd8);
    chk("fill_level", 64'(fifo_level), 64'd8);
    chk("full_ready", 64'(s_ready), 64'd0);
    tick(wd(8'h10));
    chk("pop_full_level", 64'(fifo_level), 64'd7);
    chk("pop_full_ready", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
    chk("refill_level", 64'(fifo_level), 64'd8);
    for (int i = 2; i <= 9; i++) tick(wd(8'(16 * i)));
    step();
    chk("drain8_level", 64'(fifo_level), 64'd0);
    chk("drain8_urun", 64'(underrun_count), 64'd1);
    s_data = 8'h10;
    s_valid = 1'b1;
    tick(IDLE);
    s_valid = 1'b0;
    chk("simul_urun", 64'(underrun_count), 64'd2);
    chk("simul_level", 64'(fifo_level), 64'd1);
    chk("simul_running", 64'(running), 64'd0);
    push(8'h50); push(8'h90); push(8'hD0);
    chk("simul_reprime", 64'(running), 64'd1);
    tick(64'hF000_0000_0000_0000); step(2);
    tick(wd(8'h50)); step(2);
    tick(wd(8'h90)); step(2);
    tick(wd(8'hD0)); step(2);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    chk("pre_rst_level", 64'(fifo_level), 64'd5);
    rst = 1'b1;
    step();
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_word", symbol_word, IDLE);
    chk("mid_rst_urun", 64'(underrun_count), 64'd0);
    chk("mid_rst_running", 64'(running), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(s_ready), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
